agc_gain_ctrl: RTL
==================

AGC_GAIN_CTRL -- requirements
Module: agc_gain_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: rms_TDATA width, unsigned.
REQ-002 SHALL have parameter GAIN_WIDTH, default 6: gain code width, unsigned; 0 = min gain, 2^GAIN_WIDTH-1 = max.
REQ-003 SHALL have parameter TARGET, default 64: desired RMS level.
REQ-004 SHALL have parameter HYST, default 8: half-width of the dead band around TARGET.
REQ-005 SHALL have parameter ATTACK_STEP, default 2: gain decrement per over-range sample.
REQ-006 SHALL have parameter DECAY_STEP, default 1: gain increment per under-range sample.
REQ-007 SHALL have parameter HOLDOFF, default 16: number of rms samples ignored after each gain change.
REQ-008 SHALL have parameter LOCK_COUNT, default 4: consecutive in-band samples needed to assert locked.
REQ-009 SHALL have parameter GAIN_INIT, default 32: gain code issued on enable.
REQ-010 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-011 SHALL have port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-012 SHALL have port enable, input, 1: run control.
REQ-013 SHALL have port rms_TDATA, input, WIDTH: RMS measurement from the RMS block.
REQ-014 SHALL have port rms_TVALID, input, 1: RMS sample strobe; no TREADY, so every valid sample is consumed or deliberately dropped.
REQ-015 SHALL have port gain_TDATA, output, GAIN_WIDTH: gain code to the PGA interface.
REQ-016 SHALL have port gain_TVALID, output, 1: gain code valid.
REQ-017 SHALL have port gain_TREADY, input, 1: downstream accepts gain code.
REQ-018 SHALL have port locked, output, 1: level within dead band for LOCK_COUNT consecutive samples.

Function
REQ-019 SHALL implement FSM states IDLE, UPDATE, HOLD and TRACK.
REQ-020 IDLE: when enable=1, SHALL load gain register with GAIN_INIT and enter UPDATE on the next edge.
REQ-021 UPDATE: SHALL drive gain_TVALID=1 with gain_TDATA=gain register; on the cycle with gain_TVALID and gain_TREADY both 1, SHALL clear the holdoff counter and enter HOLD.
REQ-022 UPDATE: gain_TVALID and gain_TDATA SHALL stay stable until the handshake, regardless of enable or rms_TVALID.
REQ-023 HOLD: SHALL count rms_TVALID pulses and discard their data; after the HOLDOFF-th pulse, SHALL enter TRACK (enable=1) or IDLE (enable=0).
REQ-024 TRACK, on rms_TVALID: if rms_TDATA > HI, where HI = min(TARGET+HYST, 2^WIDTH-1), SHALL set gain = max(gain-ATTACK_STEP, 0).
REQ-025 TRACK, on rms_TVALID: if rms_TDATA < LO, where LO = max(TARGET-HYST, 0), SHALL set gain = min(gain+DECAY_STEP, 2^GAIN_WIDTH-1).
REQ-026 The HI/LO comparisons SHALL be unsigned; saturation arithmetic SHALL use one extra guard bit, with no wrap-around.
REQ-027 If REQ-024 or REQ-025 changes the gain value, the block SHALL enter UPDATE, and gain_TVALID SHALL assert on the cycle after the rms_TVALID sample (latency 1).
REQ-028 If the gain is saturated (out of band, but the clamped value equals the current value), the block SHALL issue no transfer, stay in TRACK and reset the in-band counter.
REQ-029 An in-band sample (LO <= rms_TDATA <= HI) SHALL increment the in-band counter, saturating at LOCK_COUNT; locked SHALL be 1 while counter = LOCK_COUNT.
REQ-030 Any out-of-band sample, any entry to UPDATE, or leaving TRACK SHALL clear the in-band counter and deassert locked on the next cycle.
REQ-031 enable=0 in TRACK SHALL enter IDLE on the next edge; gain_TDATA SHALL hold its last value.
REQ-032 enable=0 in UPDATE SHALL take effect only after the handshake (UPDATE -> HOLD -> IDLE).
REQ-033 rms_TVALID in IDLE or UPDATE SHALL be ignored.

Reset
REQ-034 While reset_n=0, the block SHALL hold state=IDLE, gain register=GAIN_INIT, gain_TDATA=GAIN_INIT, gain_TVALID=0, locked=0 and all counters=0.
REQ-035 Reset asserted mid-UPDATE SHALL drop gain_TVALID immediately (asynchronous); after release, the block SHALL behave as from power-up.

Verification
REQ-036 Bench SHALL cover: reset release, enable=1, gain_TREADY=1 -> one transfer of gain 32, then 16 rms pulses ignored, then TRACK.
REQ-037 Bench SHALL cover: TRACK, gain=32, rms=100 -> gain_TVALID next cycle with gain 30; the following 16 samples of 100 cause no change.
REQ-038 Bench SHALL cover: TRACK, rms=60 for 4 samples -> locked=1 after the 4th; one sample of 80 -> locked=0, gain 30.
REQ-039 Bench SHALL cover: gain=1, rms=200 -> transfer gain 0; after holdoff, rms=200 -> no transfer, state stays TRACK. Gain=63, rms=0 -> no transfer.
REQ-040 Bench SHALL cover: gain_TREADY held 0 for 10 cycles during UPDATE with enable dropped and rms pulses -> gain_TVALID and gain_TDATA stable; after TREADY=1 the block enters HOLD and then IDLE.
REQ-041 Bench SHALL cover: reset_n pulsed low mid-UPDATE -> gain_TVALID=0 with no clock edge, gain_TDATA=32.

Source files
------------

// File: rtl/agc_gain_ctrl.sv
// agc_gain_ctrl: automatic gain control loop for a programmable gain amplifier.
// Compares incoming RMS measurements against a dead band around TARGET and
// steps a gain code down (attack) or up (decay), handing each new code to the
// PGA through a valid/ready transfer, then ignoring HOLDOFF samples while the
// analog path settles.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   enable       run control
//   rms_TDATA    RMS measurement (unsigned, WIDTH bits)
//   rms_TVALID   RMS sample strobe (no back-pressure)
//   gain_TDATA   gain code to the PGA (0 = min gain)
//   gain_TVALID  gain code valid
//   gain_TREADY  PGA accepts the gain code
//   locked       level stayed in the dead band for LOCK_COUNT samples
module agc_gain_ctrl #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned GAIN_WIDTH  = 6,
    parameter int unsigned TARGET      = 64,
    parameter int unsigned HYST        = 8,
    parameter int unsigned ATTACK_STEP = 2,
    parameter int unsigned DECAY_STEP  = 1,
    parameter int unsigned HOLDOFF     = 16,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned GAIN_INIT   = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [WIDTH-1:0]      rms_TDATA,
    input  logic                  rms_TVALID,
    output logic [GAIN_WIDTH-1:0] gain_TDATA,
    output logic                  gain_TVALID,
    input  logic                  gain_TREADY,
    output logic                  locked
);

    // Dead band limits, clamped to the representable measurement range.
    localparam int unsigned WMAX = (1 << WIDTH) - 1;
    localparam int unsigned HI_I =
        (TARGET + HYST > WMAX) ? WMAX : TARGET + HYST;
    localparam int unsigned LO_I =
        (TARGET > HYST) ? TARGET - HYST : 0;
    localparam logic [WIDTH-1:0] HI = WIDTH'(HI_I);
    localparam logic [WIDTH-1:0] LO = WIDTH'(LO_I);

    localparam int GW1 = GAIN_WIDTH + 1;
    localparam logic [GAIN_WIDTH:0]   ATK   = GW1'(ATTACK_STEP);
    localparam logic [GAIN_WIDTH:0]   DEC   = GW1'(DECAY_STEP);
    localparam logic [GAIN_WIDTH-1:0] GINIT = GAIN_WIDTH'(GAIN_INIT);

    localparam int HC_W = $clog2(HOLDOFF + 1);
    localparam int LC_W = $clog2(LOCK_COUNT + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLDOFF - 1);
    localparam logic [LC_W-1:0] LOCK_MAX  = LC_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPDATE,
        S_HOLD,
        S_TRACK
    } state_t;

    state_t                state_q, state_d;
    logic [GAIN_WIDTH-1:0] gain_q, gain_d;
    logic                  vld_q, vld_d;
    logic [HC_W-1:0]       hold_q, hold_d;
    logic [LC_W-1:0]       lock_q, lock_d;
    logic                  locked_q;

    logic                  over;
    logic                  under;
    logic [GAIN_WIDTH:0]   dn_ext;
    logic [GAIN_WIDTH:0]   up_ext;
    logic [GAIN_WIDTH-1:0] gain_dn;
    logic [GAIN_WIDTH-1:0] gain_up;
    logic [GAIN_WIDTH-1:0] gain_new;

    assign over  = rms_TDATA > HI;
    assign under = rms_TDATA < LO;

    // The guard bit flags a borrow (below zero) or carry (past full scale),
    // and the result is clamped instead of wrapping.
    assign dn_ext  = {1'b0, gain_q} - ATK;
    assign up_ext  = {1'b0, gain_q} + DEC;
    assign gain_dn = dn_ext[GAIN_WIDTH] ? '0 : dn_ext[GAIN_WIDTH-1:0];
    assign gain_up = up_ext[GAIN_WIDTH] ? '1 : up_ext[GAIN_WIDTH-1:0];
    assign gain_new = over ? gain_dn : gain_up;

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        vld_d   = vld_q;
        hold_d  = hold_q;
        lock_d  = lock_q;
        unique case (state_q)
            S_IDLE: begin
                hold_d = '0;
                lock_d = '0;
                if (enable) begin
                    gain_d  = GINIT;
                    vld_d   = 1'b1;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                // Code is frozen until accepted; enable and rms are ignored.
                lock_d = '0;
                if (gain_TREADY) begin
                    vld_d   = 1'b0;
                    hold_d  = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                lock_d = '0;
                if (rms_TVALID) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = enable ? S_TRACK : S_IDLE;
                    end else begin
                        hold_d = hold_q + HC_W'(1);
                    end
                end
            end
            S_TRACK: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    lock_d  = '0;
                end else if (rms_TVALID) begin
                    if (over || under) begin
                        lock_d = '0;
                        // A saturated gain produces no transfer.
                        if (gain_new != gain_q) begin
                            gain_d  = gain_new;
                            vld_d   = 1'b1;
                            state_d = S_UPDATE;
                        end
                    end else if (lock_q != LOCK_MAX) begin
                        lock_d = lock_q + LC_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            gain_q   <= GINIT;
            vld_q    <= 1'b0;
            hold_q   <= '0;
            lock_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gain_q   <= gain_d;
            vld_q    <= vld_d;
            hold_q   <= hold_d;
            lock_q   <= lock_d;
            locked_q <= (lock_d == LOCK_MAX);
        end
    end

    assign gain_TDATA  = gain_q;
    assign gain_TVALID = vld_q;
    assign locked      = locked_q;

endmodule
